// File: rtl/frame_swap_controller.sv
// Frame sequencer and double-buffer owner for the drawing pipeline.
// It starts the drawing manager, acknowledges each finished frame, and swaps the
// draw/display buffers only when a finished frame meets a display vsync boundary.
// It also counts presented frames and vsync boundaries missed by drawing overruns.
module frame_swap_controller #(
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int MISS_COUNT_WIDTH  = 8,
  parameter int VSYNC_ACTIVE_HIGH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         vsync,
  input  logic                         frame_done,
  output logic                         draw_start,
  output logic                         draw_ack,
  output logic                         draw_buf_sel,
  output logic                         disp_buf_sel,
  output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
  output logic [MISS_COUNT_WIDTH-1:0]  missed_vsync,
  output logic                         busy
);

  // Idle level of vsync, so reset does not fake a boundary on the first cycle.
  localparam logic VSYNC_IDLE = (VSYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DRAWING,
    S_WAIT_VSYNC,
    S_SWAP
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   started_q;
  logic   vsync_q;
  logic   vsync_edge;
  logic   enter_swap;
  logic   miss_inc;

  // The miss counter holds at all-ones so a long stall never looks like a small one.
  function automatic logic [MISS_COUNT_WIDTH-1:0] sat_inc(
    input logic [MISS_COUNT_WIDTH-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + MISS_COUNT_WIDTH'(1);
  endfunction

  assign vsync_edge = (VSYNC_ACTIVE_HIGH != 0) ? (vsync & ~vsync_q)
                                               : (~vsync & vsync_q);
  assign busy         = (state_q != S_IDLE);
  assign disp_buf_sel = ~draw_buf_sel;

  // Next-state decode plus the one-cycle start/ack strobes.
  always_comb begin
    state_d    = state_q;
    draw_start = 1'b0;
    draw_ack   = 1'b0;
    enter_swap = 1'b0;
    miss_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_START;
        end
      end
      S_START: begin
        // The very first frame is launched with start; later restarts release a
        // manager that is parked in its frame-done state, which needs an ack.
        draw_start = ~started_q;
        draw_ack   = started_q;
        state_d    = S_DRAWING;
      end
      S_DRAWING: begin
        if (frame_done && vsync_edge) begin
          state_d    = S_SWAP;
          enter_swap = 1'b1;
        end else if (frame_done) begin
          state_d = S_WAIT_VSYNC;
        end else if (vsync_edge) begin
          miss_inc = 1'b1;
        end
      end
      S_WAIT_VSYNC: begin
        // frame_done stays high until acked, so only the boundary matters here.
        if (vsync_edge) begin
          state_d    = S_SWAP;
          enter_swap = 1'b1;
        end
      end
      S_SWAP: begin
        if (enable) begin
          draw_ack = 1'b1;
          state_d  = S_DRAWING;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, vsync history, buffer select and counters; swap effects land on SWAP entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      started_q    <= 1'b0;
      vsync_q      <= VSYNC_IDLE;
      draw_buf_sel <= 1'b0;
      frame_count  <= '0;
      missed_vsync <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      if (state_q == S_START) begin
        started_q <= 1'b1;
      end
      if (enter_swap) begin
        draw_buf_sel <= ~draw_buf_sel;
        frame_count  <= frame_count + FRAME_COUNT_WIDTH'(1);
      end
      if (miss_inc) begin
        missed_vsync <= sat_inc(missed_vsync);
      end
    end
  end

endmodule

// File: tb/tb_frame_swap_controller.sv
// Directed bench for frame_swap_controller with a per-cycle reference model.
// Narrow counters are used so frame-count wrap and miss saturation are reachable.
module tb_frame_swap_controller;

  localparam int FCW = 3;
  localparam int MCW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           vsync;
  logic           frame_done;
  logic           draw_start;
  logic           draw_ack;
  logic           draw_buf_sel;
  logic           disp_buf_sel;
  logic [FCW-1:0] frame_count;
  logic [MCW-1:0] missed_vsync;
  logic           busy;

  frame_swap_controller #(
    .FRAME_COUNT_WIDTH(FCW),
    .MISS_COUNT_WIDTH (MCW),
    .VSYNC_ACTIVE_HIGH(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .vsync       (vsync),
    .frame_done  (frame_done),
    .draw_start  (draw_start),
    .draw_ack    (draw_ack),
    .draw_buf_sel(draw_buf_sel),
    .disp_buf_sel(disp_buf_sel),
    .frame_count (frame_count),
    .missed_vsync(missed_vsync),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases of a frame's life, unbounded counters reduced on compare.
  localparam int PH_IDLE = 0;
  localparam int PH_KICK = 1;
  localparam int PH_DRAW = 2;
  localparam int PH_WAIT = 3;
  localparam int PH_SWAP = 4;

  int m_phase   = PH_IDLE;
  int m_next;
  bit m_started = 1'b0;
  bit m_vprev   = 1'b0;
  bit m_buf     = 1'b0;
  bit m_edge;
  int m_frames  = 0;
  int m_miss    = 0;
  int e_miss;

  always @(posedge clk) begin
    if (rst) begin
      m_phase   = PH_IDLE;
      m_started = 1'b0;
      m_vprev   = 1'b0;
      m_buf     = 1'b0;
      m_frames  = 0;
      m_miss    = 0;
    end else begin
      m_edge  = vsync && !m_vprev;
      m_vprev = vsync;
      m_next  = m_phase;
      if (m_phase == PH_IDLE && enable) m_next = PH_KICK;
      if (m_phase == PH_KICK) begin
        m_started = 1'b1;
        m_next    = PH_DRAW;
      end
      if (m_phase == PH_DRAW) begin
        if (frame_done && m_edge) m_next = PH_SWAP;
        else if (frame_done)      m_next = PH_WAIT;
        else if (m_edge)          m_miss++;
      end
      if (m_phase == PH_WAIT && m_edge) m_next = PH_SWAP;
      if (m_phase == PH_SWAP) m_next = enable ? PH_DRAW : PH_IDLE;
      if (m_next == PH_SWAP) begin
        m_buf = !m_buf;
        m_frames++;
      end
      m_phase = m_next;
    end
    #1;
    if (chk_en) begin
      e_miss = (m_miss > (1 << MCW) - 1) ? (1 << MCW) - 1 : m_miss;
      chk("model_draw_start", int'(draw_start), int'(m_phase == PH_KICK && !m_started));
      chk("model_draw_ack", int'(draw_ack),
          int'((m_phase == PH_KICK && m_started) || (m_phase == PH_SWAP && enable)));
      chk("model_busy", int'(busy), int'(m_phase != PH_IDLE));
      chk("model_draw_buf_sel", int'(draw_buf_sel), int'(m_buf));
      chk("model_disp_buf_sel", int'(disp_buf_sel), int'(!m_buf));
      chk("model_frame_count", int'(frame_count), m_frames % (1 << FCW));
      chk("model_missed_vsync", int'(missed_vsync), e_miss);
    end
  end

  // One clock edge; returns on the following negedge so inputs change away from posedge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_draw_start"}, int'(draw_start), 0);
    chk({tag, "_draw_ack"}, int'(draw_ack), 0);
    chk({tag, "_draw_buf_sel"}, int'(draw_buf_sel), 0);
    chk({tag, "_disp_buf_sel"}, int'(disp_buf_sel), 1);
    chk({tag, "_frame_count"}, int'(frame_count), 0);
    chk({tag, "_missed_vsync"}, int'(missed_vsync), 0);
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    vsync      = 1'b0;
    frame_done = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk_reset_vals("reset");

    // T1: first START issues draw_start only.
    rst    = 1'b0;
    enable = 1'b1;
    cyc(1);
    chk("t1_draw_start", int'(draw_start), 1);
    chk("t1_draw_ack", int'(draw_ack), 0);
    chk("t1_busy", int'(busy), 1);
    cyc(1);
    chk("t1_start_one_cycle", int'(draw_start), 0);

    // T2: finished frame waits 10 cycles for vsync, then swaps.
    frame_done = 1'b1;
    cyc(10);
    chk("t2_no_swap_yet", int'(frame_count), 0);
    vsync = 1'b1;
    cyc(1);
    chk("t2_draw_buf_sel", int'(draw_buf_sel), 1);
    chk("t2_disp_buf_sel", int'(disp_buf_sel), 0);
    chk("t2_frame_count", int'(frame_count), 1);
    chk("t2_draw_ack", int'(draw_ack), 1);
    frame_done = 1'b0;
    cyc(1);
    chk("t2_ack_one_cycle", int'(draw_ack), 0);
    vsync = 1'b0;
    cyc(1);

    // T3: two boundaries while still drawing.
    for (int i = 0; i < 2; i++) begin
      vsync = 1'b1;
      cyc(1);
      vsync = 1'b0;
      cyc(1);
    end
    chk("t3_missed", int'(missed_vsync), 2);
    chk("t3_sel_unchanged", int'(draw_buf_sel), 1);
    chk("t3_count_unchanged", int'(frame_count), 1);

    // T4: done and vsync in the same cycle swap without a miss.
    frame_done = 1'b1;
    vsync      = 1'b1;
    cyc(1);
    chk("t4_missed", int'(missed_vsync), 2);
    chk("t4_frame_count", int'(frame_count), 2);
    chk("t4_draw_buf_sel", int'(draw_buf_sel), 0);
    chk("t4_draw_ack", int'(draw_ack), 1);
    frame_done = 1'b0;
    vsync      = 1'b0;
    cyc(1);

    // T5: enable dropped mid-frame; frame completes, parks in IDLE, restart acks.
    enable     = 1'b0;
    frame_done = 1'b1;
    cyc(1);
    vsync = 1'b1;
    cyc(1);
    chk("t5_swap_count", int'(frame_count), 3);
    chk("t5_swap_no_ack", int'(draw_ack), 0);
    cyc(1);
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_no_ack", int'(draw_ack), 0);
    vsync  = 1'b0;
    enable = 1'b1;
    cyc(1);
    chk("t5_restart_ack", int'(draw_ack), 1);
    chk("t5_restart_no_start", int'(draw_start), 0);
    frame_done = 1'b0;
    cyc(1);
    chk("t5_restart_ack_once", int'(draw_ack), 0);

    // T6: five more misses saturate the 2-bit counter, then reset mid-drawing.
    for (int i = 0; i < 5; i++) begin
      vsync = 1'b1;
      cyc(1);
      vsync = 1'b0;
      cyc(1);
    end
    chk("t6_miss_saturated", int'(missed_vsync), 3);
    rst = 1'b1;
    cyc(1);
    chk_reset_vals("t6_midframe_reset");

    // Nine back-to-back frames wrap the 3-bit frame counter; last one stops.
    rst = 1'b0;
    cyc(2);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) enable = 1'b0;
      frame_done = 1'b1;
      vsync      = 1'b1;
      cyc(1);
      frame_done = 1'b0;
      vsync      = 1'b0;
      cyc(1);
    end
    chk("wrap_frame_count", int'(frame_count), 1);
    chk("wrap_draw_buf_sel", int'(draw_buf_sel), 1);
    chk("wrap_idle_busy", int'(busy), 0);

    // Boundaries seen while idle are not misses.
    for (int i = 0; i < 3; i++) begin
      vsync = 1'b1;
      cyc(1);
      vsync = 1'b0;
      cyc(1);
    end
    chk("idle_vsync_ignored", int'(missed_vsync), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
